// File: rtl/dsp48a1_mac_sequencer.sv
// Job-level MAC controller driving one DSP48A1 slice: P = sum(A_i*B_i) over LEN beats.
// Optional abort feature: define SEQ_ABORT_EN to add the abort/aborted ports.
module dsp48a1_mac_sequencer #(
  parameter int unsigned WIDTH1  = 18,
  parameter int unsigned WIDTH2  = 48,
  parameter int unsigned LEN_W   = 16,
  parameter int unsigned DSP_LAT = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH1-1:0] in_a,
  input  logic [WIDTH1-1:0] in_b,
  output logic [WIDTH1-1:0] dsp_a,
  output logic [WIDTH1-1:0] dsp_b,
  output logic [7:0]        dsp_opmode,
  output logic              dsp_ce,
  output logic              dsp_rstp,
  input  logic [WIDTH2-1:0] dsp_p,
  output logic [WIDTH2-1:0] res_data,
  output logic              res_valid,
`ifdef SEQ_ABORT_EN
  input  logic              abort,
  output logic              aborted,
`endif
  output logic              busy
);

  localparam logic [7:0] OpFirst = 8'b0000_0001;  // X=M, Z=0
  localparam logic [7:0] OpAcc   = 8'b0000_1001;  // X=M, Z=P
  localparam logic [7:0] OpHold  = 8'b0000_1000;  // X=0, Z=P

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StZero} state_e;

  state_e              state_q, state_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [LEN_W-1:0]    count_q, count_d;
  logic [WIDTH1-1:0]   dsp_a_q, dsp_a_d;
  logic [WIDTH1-1:0]   dsp_b_q, dsp_b_d;
  logic [7:0]          opmode_q, opmode_d;
  logic [WIDTH2-1:0]   res_data_q, res_data_d;
  logic                res_valid_q, res_valid_d;
  logic [DSP_LAT-1:0]  tag_vld_q, tag_vld_d;
  // Only stage 1 drives OPMODE, so the first-beat flag is kept for that stage alone.
  logic                tag_first_q, tag_first_d;
  logic                abort_hit;
  logic                xfer;

`ifdef SEQ_ABORT_EN
  logic aborted_q, aborted_d;
  assign abort_hit = abort & ((state_q == StRun) | (state_q == StDrain));
  assign aborted   = aborted_q;
`else
  assign abort_hit = 1'b0;
`endif

  // Abort wins over a transfer in the same cycle, so the source must not see ready.
  assign in_ready   = (state_q == StRun) & ~abort_hit;
  assign xfer       = in_valid & in_ready;
  assign dsp_a      = dsp_a_q;
  assign dsp_b      = dsp_b_q;
  assign dsp_opmode = opmode_q;
  assign dsp_ce     = 1'b1;
  assign dsp_rstp   = (state_q == StIdle) | (state_q == StZero);
  assign res_data   = res_data_q;
  assign res_valid  = res_valid_q;
  assign busy       = (state_q == StRun) | (state_q == StDrain);

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    count_d     = count_q;
    dsp_a_d     = dsp_a_q;
    dsp_b_d     = dsp_b_q;
    res_data_d  = res_data_q;
    res_valid_d = 1'b0;
    tag_vld_d   = {tag_vld_q[DSP_LAT-2:0], xfer};
    tag_first_d = xfer & (count_q == '0);
`ifdef SEQ_ABORT_EN
    aborted_d   = 1'b0;
`endif

    if (tag_vld_q[0]) begin
      opmode_d = tag_first_q ? OpFirst : OpAcc;
    end else begin
      opmode_d = OpHold;
    end

    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (len != '0) begin
            state_d = StRun;
            len_d   = len;
            count_d = '0;
          end else begin
            state_d = StZero;
          end
        end
      end
      StRun: begin
        if (xfer) begin
          dsp_a_d = in_a;
          dsp_b_d = in_b;
          count_d = count_q + LEN_W'(1);
          if (count_q == len_q - LEN_W'(1)) begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        // Empty tag pipe means the last product has already landed in P.
        if (tag_vld_q == '0) begin
          res_data_d  = dsp_p;
          res_valid_d = 1'b1;
          state_d     = StIdle;
        end
      end
      StZero: begin
        res_data_d  = '0;
        res_valid_d = 1'b1;
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (abort_hit) begin
      state_d     = StIdle;
      tag_vld_d   = '0;
      tag_first_d = 1'b0;
      res_data_d  = res_data_q;
      res_valid_d = 1'b0;
`ifdef SEQ_ABORT_EN
      aborted_d   = 1'b1;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      len_q       <= '0;
      count_q     <= '0;
      dsp_a_q     <= '0;
      dsp_b_q     <= '0;
      opmode_q    <= 8'h00;
      res_data_q  <= '0;
      res_valid_q <= 1'b0;
      tag_vld_q   <= '0;
      tag_first_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      count_q     <= count_d;
      dsp_a_q     <= dsp_a_d;
      dsp_b_q     <= dsp_b_d;
      opmode_q    <= opmode_d;
      res_data_q  <= res_data_d;
      res_valid_q <= res_valid_d;
      tag_vld_q   <= tag_vld_d;
      tag_first_q <= tag_first_d;
    end
  end

`ifdef SEQ_ABORT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aborted_q <= 1'b0;
    end else begin
      aborted_q <= aborted_d;
    end
  end
`endif

endmodule

// File: tb/tb_dsp48a1_mac_sequencer.sv
// Directed bench for dsp48a1_mac_sequencer with a behavioural DSP48A1 slice model on P.
module tb_dsp48a1_mac_sequencer;

  localparam int DSP_LAT = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] len = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [17:0] in_a = '0;
  logic [17:0] in_b = '0;
  logic [17:0] dsp_a;
  logic [17:0] dsp_b;
  logic [7:0]  dsp_opmode;
  logic        dsp_ce;
  logic        dsp_rstp;
  logic [47:0] dsp_p;
  logic [47:0] res_data;
  logic        res_valid;
  logic        busy;
`ifdef SEQ_ABORT_EN
  logic        abort = 1'b0;
  logic        aborted;
`endif

  int total = 0;
  int bad = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dsp48a1_mac_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .len        (len),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .dsp_a      (dsp_a),
    .dsp_b      (dsp_b),
    .dsp_opmode (dsp_opmode),
    .dsp_ce     (dsp_ce),
    .dsp_rstp   (dsp_rstp),
    .dsp_p      (dsp_p),
    .res_data   (res_data),
    .res_valid  (res_valid),
`ifdef SEQ_ABORT_EN
    .abort      (abort),
    .aborted    (aborted),
`endif
    .busy       (busy)
  );

  // Slice model: A1REG=B1REG=MREG=PREG=OPMODEREG=1, RSTP/RSTM synchronous.
  logic signed [17:0] a1 = '0;
  logic signed [17:0] b1 = '0;
  logic signed [35:0] m = '0;
  logic [7:0]  opreg = '0;
  logic [47:0] p = '0;
  logic [47:0] xmux;
  logic [47:0] zmux;
  assign dsp_p = p;

  always_comb begin
    xmux = '0;
    zmux = '0;
    if (opreg[1:0] == 2'b01) xmux = {{12{m[35]}}, m};
    if (opreg[3:2] == 2'b10) zmux = p;
  end

  always @(posedge clk) begin
    if (dsp_ce) begin
      a1 <= dsp_a;
      b1 <= dsp_b;
      opreg <= dsp_opmode;
    end
    if (dsp_rstp) begin
      m <= '0;
      p <= '0;
    end else if (dsp_ce) begin
      m <= a1 * b1;
      p <= opreg[7] ? zmux - xmux : zmux + xmux;
    end
  end

  typedef struct packed {
    logic [15:0]      len;
    logic [3:0][17:0] a;
    logic [3:0][17:0] b;
    logic [3:0]       gap;
    logic             mid_start;
    logic [47:0]      exp;
  } vec_t;

  vec_t vec [8];

  function automatic vec_t mk(input int l, input int a0, input int a1v, input int a2,
                              input int a3, input int b0, input int b1v, input int b2,
                              input int b3, input int gap, input bit mid,
                              input logic [47:0] e);
    vec_t v;
    v.len = l[15:0];
    v.a[0] = a0[17:0];
    v.a[1] = a1v[17:0];
    v.a[2] = a2[17:0];
    v.a[3] = a3[17:0];
    v.b[0] = b0[17:0];
    v.b[1] = b1v[17:0];
    v.b[2] = b2[17:0];
    v.b[3] = b3[17:0];
    v.gap = gap[3:0];
    v.mid_start = mid;
    v.exp = e;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic run_job(input int idx);
    vec_t v;
    int k;
    int t;
    v = vec[idx];
    k = 0;
    @(negedge clk);
    start = 1'b1;
    len = v.len;
    @(negedge clk);
    start = 1'b0;
    chk("busy_run", busy, 1);
    if (v.mid_start) begin
      start = 1'b1;
      len = 16'd7;
      @(negedge clk);
      start = 1'b0;
    end
    for (int i = 0; i < int'(v.len); i++) begin
      in_valid = 1'b1;
      in_a = v.a[i];
      in_b = v.b[i];
      chk("ready_beat", in_ready, 1);
      @(negedge clk);
      k = cyc;
      in_valid = 1'b0;
      if (i < int'(v.len) - 1) begin
        for (int g = 0; g < int'(v.gap); g++) begin
          @(negedge clk);
          chk("ready_gap", in_ready, 1);
          if (g >= 1) chk("opmode_gap", dsp_opmode, 8'h08);
        end
      end
    end
    t = 0;
    while (!res_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("res_valid_seen", res_valid, 1);
    chk("latency", cyc - k, DSP_LAT + 1);
    chk("res_data", res_data, v.exp);
    @(negedge clk);
    chk("res_pulse", res_valid, 0);
    chk("busy_idle", busy, 0);
  endtask

  initial begin
    vec[0] = mk(3, 2, 4, 6, 0, 3, 5, 7, 0, 0, 1'b0, 48'd68);
    vec[1] = mk(4, 1, 1, 1, 1, 1, 1, 1, 1, 2, 1'b0, 48'd4);
    vec[2] = mk(1, 3, 0, 0, 0, -5, 0, 0, 0, 0, 1'b1, 48'hFFFF_FFFF_FFF1);
    vec[3] = mk(1, 10, 0, 0, 0, 10, 0, 0, 0, 0, 1'b0, 48'd100);
    vec[4] = mk(2, -131072, 131071, 0, 0, -131072, -131072, 0, 0, 0, 1'b0, 48'h2_0000);
    vec[5] = mk(4, 100, -7, 0, 1000, -1, -7, 5, 1000, 1, 1'b0, 48'd999949);
    vec[6] = mk(1, 7, 0, 0, 0, 8, 0, 0, 0, 0, 1'b0, 48'd56);
    vec[7] = mk(1, 2, 0, 0, 0, 2, 0, 0, 0, 0, 1'b0, 48'd4);

    repeat (3) @(negedge clk);
    chk("rst_ready", in_ready, 0);
    chk("rst_dsp_a", dsp_a, 0);
    chk("rst_opmode", dsp_opmode, 8'h00);
    chk("rst_ce", dsp_ce, 1);
    chk("rst_rstp", dsp_rstp, 1);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;

    run_job(0);
    run_job(1);

    // Zero-length job: RES_VALID one cycle after START is taken, never busy.
    @(negedge clk);
    start = 1'b1;
    len = 16'd0;
    @(negedge clk);
    start = 1'b0;
    chk("zero_busy", busy, 0);
    chk("zero_early", res_valid, 0);
    @(negedge clk);
    chk("zero_valid", res_valid, 1);
    chk("zero_data", res_data, 0);
    chk("zero_busy2", busy, 0);
    @(negedge clk);
    chk("zero_pulse", res_valid, 0);

    run_job(2);
    run_job(3);
    run_job(4);
    run_job(5);

    // Reset in the middle of a 5-beat job.
    @(negedge clk);
    start = 1'b1;
    len = 16'd5;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_a = 18'd9;
      in_b = 18'd9;
      @(negedge clk);
    end
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("mid_rst_ready", in_ready, 0);
    chk("mid_rst_dsp_a", dsp_a, 0);
    chk("mid_rst_dsp_b", dsp_b, 0);
    chk("mid_rst_opmode", dsp_opmode, 8'h00);
    chk("mid_rst_rstp", dsp_rstp, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_res_data", res_data, 0);
    @(negedge clk);
    @(negedge clk);
    chk("mid_rst_no_valid", res_valid, 0);
    rst = 1'b0;
    run_job(6);

`ifdef SEQ_ABORT_EN
    begin
      bit any_valid;
      any_valid = 1'b0;
      @(negedge clk);
      start = 1'b1;
      len = 16'd2;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 2; i++) begin
        in_valid = 1'b1;
        in_a = 18'd5;
        in_b = 18'd5;
        @(negedge clk);
      end
      in_valid = 1'b0;
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("abort_pulse", aborted, 1);
      chk("abort_busy", busy, 0);
      chk("abort_rstp", dsp_rstp, 1);
      for (int i = 0; i < 8; i++) begin
        if (res_valid) any_valid = 1'b1;
        @(negedge clk);
      end
      chk("abort_no_valid", any_valid, 0);
      chk("abort_pulse_end", aborted, 0);
      run_job(7);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
